// File: rtl/fft_lane_mux_if.sv
// Bus bundle for fft_lane_mux: stage inputs, lane source and registered outputs.
// master drives the datapath inputs; slave is the mux itself.
interface fft_lane_mux_if #(
   parameter int unsigned LANE_W    = 34,
   parameter int unsigned LANES     = 4,
   parameter int unsigned FRAME_LEN = 16
);
   localparam int unsigned W  = LANE_W * LANES;
   localparam int unsigned SW = $clog2(FRAME_LEN);

   logic          en;
   logic          sync;
   logic          mux_flag;
   logic [W-1:0]  data_in_1;
   logic [W-1:0]  data_in_2;
   logic [W-1:0]  data_in_3;
   logic [W-1:0]  data_out;
   logic          out_valid;
   logic          ins_flag;
   logic          ins_miss;
   logic [SW-1:0] slot;

   modport master (
      output en, sync, mux_flag, data_in_1, data_in_2, data_in_3,
      input  data_out, out_valid, ins_flag, ins_miss, slot
   );

   modport slave (
      input  en, sync, mux_flag, data_in_1, data_in_2, data_in_3,
      output data_out, out_valid, ins_flag, ins_miss, slot
   );
endinterface

// File: rtl/fft_lane_mux.sv
// FFT stage output selector: registers one of two words per slot and, once per
// frame, injects a word assembled from lanes collected over a capture window.
module fft_lane_mux #(
   parameter int unsigned LANE_W    = 34,
   parameter int unsigned LANES     = 4,
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned CAP_START = 14,
   parameter int unsigned INS_SLOT  = 2
) (
   input logic           clk,
   input logic           rst_n,
   fft_lane_mux_if.slave bus
);
   localparam int unsigned W  = LANE_W * LANES;
   localparam int unsigned SW = $clog2(FRAME_LEN);
   localparam logic [SW-1:0] INS_IDX = SW'(INS_SLOT);

   // True when the insertion slot collides with any capture slot.
   function automatic bit ins_in_window();
      for (int unsigned k = 0; k < LANES; k++) begin
         if (((CAP_START + k) % FRAME_LEN) == INS_SLOT) return 1'b1;
      end
      return 1'b0;
   endfunction

   localparam bit BAD_CFG = ins_in_window()
                          || ((FRAME_LEN & (FRAME_LEN - 1)) != 0)
                          || (FRAME_LEN < LANES + 1)
                          || (CAP_START >= FRAME_LEN)
                          || (INS_SLOT >= FRAME_LEN);

   if (BAD_CFG) begin : g_bad_cfg
      $fatal(1, "fft_lane_mux: illegal parameter set (insertion slot inside capture window or bad frame length)");
   end

   if (LANES > 1) begin : g_unused_hi
      logic unused_hi_c;
      assign unused_hi_c = ^bus.data_in_3[W-1:LANE_W];
   end

   logic [SW-1:0]                 slot_q, slot_nxt, cur_c;
   logic [LANES-1:0][LANE_W-1:0]  lane_q, lane_nxt;
   logic [LANES-1:0]              mask_q, mask_nxt;
   logic [W-1:0]                  dout_q, dout_nxt;
   logic                          valid_q, valid_nxt;
   logic                          ins_q, ins_nxt;
   logic                          miss_q, miss_nxt;

   // Next-state: slot advance, lane capture, insertion/mux selection.
   always_comb begin
      cur_c     = bus.sync ? '0 : slot_q;
      slot_nxt  = cur_c;
      lane_nxt  = lane_q;
      mask_nxt  = bus.sync ? '0 : mask_q;
      dout_nxt  = dout_q;
      valid_nxt = 1'b0;
      ins_nxt   = 1'b0;
      miss_nxt  = 1'b0;

      if (bus.en) begin
         slot_nxt  = cur_c + SW'(1);
         valid_nxt = 1'b1;
         dout_nxt  = bus.mux_flag ? bus.data_in_1 : bus.data_in_2;

         if (cur_c == INS_IDX) begin
            // Completeness judged after any same-cycle sync clear.
            if (&mask_nxt) begin
               dout_nxt = W'(lane_q);
               ins_nxt  = 1'b1;
            end else begin
               miss_nxt = 1'b1;
            end
            mask_nxt = '0;
         end

         for (int unsigned k = 0; k < LANES; k++) begin
            if (cur_c == SW'((CAP_START + k) % FRAME_LEN)) begin
               lane_nxt[k] = bus.data_in_3[LANE_W-1:0];
               mask_nxt[k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= '0;
         lane_q  <= '0;
         mask_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ins_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         slot_q  <= slot_nxt;
         lane_q  <= lane_nxt;
         mask_q  <= mask_nxt;
         dout_q  <= dout_nxt;
         valid_q <= valid_nxt;
         ins_q   <= ins_nxt;
         miss_q  <= miss_nxt;
      end
   end

   assign bus.slot      = slot_q;
   assign bus.data_out  = dout_q;
   assign bus.out_valid = valid_q;
   assign bus.ins_flag  = ins_q;
   assign bus.ins_miss  = miss_q;
endmodule

// File: tb/tb_fft_lane_mux.sv
// Scoreboard bench for fft_lane_mux: default parameter set plus a 16x8-lane,
// 32-slot variant; the driver queues expectations, a negedge monitor checks them.
module tb_fft_lane_mux;
   localparam int K_NONE = 0;
   localparam int K_INS  = 1;
   localparam int K_MISS = 2;

   localparam logic [135:0] W1 = {34'h101, 34'h100, 34'h10F, 34'h10E};
   localparam logic [135:0] W2 = {8'h0, 128'hC01B_C01A_C019_C018_C017_C016_C015_C014};

   typedef struct {
      int           dut;
      logic [135:0] dout;
      logic         valid;
      logic         ins;
      logic         miss;
      int           slot;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_cmp;
   int   n_bad;
   int   exp_slot [2];
   logic [135:0] exp_dout [2];
   int   flen [2];
   int   ins_slot [2];
   int   tagc;

   fft_lane_mux_if #(.LANE_W(34), .LANES(4), .FRAME_LEN(16)) bus1 ();
   fft_lane_mux_if #(.LANE_W(16), .LANES(8), .FRAME_LEN(32)) bus2 ();

   fft_lane_mux #(.LANE_W(34), .LANES(4), .FRAME_LEN(16), .CAP_START(14), .INS_SLOT(2))
      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   fft_lane_mux #(.LANE_W(16), .LANES(8), .FRAME_LEN(32), .CAP_START(20), .INS_SLOT(30))
      u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [135:0] act, logic [135:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void compare(exp_t x);
      if (x.dut == 0) begin
         check("d1_data_out",  136'(bus1.data_out),  x.dout);
         check("d1_out_valid", 136'(bus1.out_valid), 136'(x.valid));
         check("d1_ins_flag",  136'(bus1.ins_flag),  136'(x.ins));
         check("d1_ins_miss",  136'(bus1.ins_miss),  136'(x.miss));
         check("d1_slot",      136'(bus1.slot),      136'(x.slot));
      end else begin
         check("d2_data_out",  136'(bus2.data_out),  x.dout);
         check("d2_out_valid", 136'(bus2.out_valid), 136'(x.valid));
         check("d2_ins_flag",  136'(bus2.ins_flag),  136'(x.ins));
         check("d2_ins_miss",  136'(bus2.ins_miss),  136'(x.miss));
         check("d2_slot",      136'(bus2.slot),      136'(x.slot));
      end
   endfunction

   // Monitor: outputs are compared on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (sb.size() > 0) compare(sb.pop_front());
   end

   task automatic cyc(input int d, input logic e, input logic s, input logic mf,
                      input logic [135:0] v1, input logic [135:0] v2, input logic [135:0] v3,
                      input int kind, input logic [135:0] word);
      exp_t         x;
      int           cur;
      logic [135:0] sel;
      if (d == 0) begin
         bus1.en = e; bus1.sync = s; bus1.mux_flag = mf;
         bus1.data_in_1 = v1; bus1.data_in_2 = v2; bus1.data_in_3 = v3;
      end else begin
         bus2.en = e; bus2.sync = s; bus2.mux_flag = mf;
         bus2.data_in_1 = v1[127:0]; bus2.data_in_2 = v2[127:0]; bus2.data_in_3 = v3[127:0];
      end
      cur   = s ? 0 : exp_slot[d];
      x.dut = d;
      if (e) begin
         exp_slot[d] = (cur + 1) % flen[d];
         sel = (kind == K_INS) ? word : (mf ? v1 : v2);
         exp_dout[d] = (d == 1) ? {8'h0, sel[127:0]} : sel;
         x.valid = 1'b1;
         x.ins   = (kind == K_INS);
         x.miss  = (kind == K_MISS);
      end else begin
         exp_slot[d] = cur;
         x.valid = 1'b0;
         x.ins   = 1'b0;
         x.miss  = 1'b0;
      end
      x.dout = exp_dout[d];
      x.slot = exp_slot[d];
      @(posedge clk);
      #1;
      sb.push_back(x);
   endtask

   // n enabled cycles; 'kind' applies to any insertion-slot hit in this run.
   task automatic run(input int d, input int n, input int kind, input logic mf_ins,
                      input logic [135:0] word);
      int cur;
      bit hit;
      for (int i = 0; i < n; i++) begin
         cur = exp_slot[d];
         hit = (cur == ins_slot[d]);
         cyc(d, 1'b1, 1'b0, hit ? mf_ins : 1'b1,
             136'h0A000 + 136'(tagc), 136'h0B000 + 136'(tagc),
             ((d == 1) ? 136'h0C000 : 136'h00100) + 136'(cur),
             hit ? kind : K_NONE, word);
         tagc++;
      end
   endtask

   initial begin
      exp_t z;
      n_cmp = 0; n_bad = 0; tagc = 1;
      flen[0] = 16; flen[1] = 32;
      ins_slot[0] = 2; ins_slot[1] = 30;
      for (int d = 0; d < 2; d++) begin
         exp_slot[d] = 0;
         exp_dout[d] = '0;
      end
      bus1.en = 0; bus1.sync = 0; bus1.mux_flag = 0;
      bus1.data_in_1 = '0; bus1.data_in_2 = '0; bus1.data_in_3 = '0;
      bus2.en = 0; bus2.sync = 0; bus2.mux_flag = 0;
      bus2.data_in_1 = '0; bus2.data_in_2 = '0; bus2.data_in_3 = '0;
      z.dout = '0; z.valid = 0; z.ins = 0; z.miss = 0; z.slot = 0;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      z.dut = 0; compare(z);
      z.dut = 1; compare(z);
      @(negedge clk); #1;
      rst_n = 1'b1;

      // Frame after reset: insertion slot reached with no lanes -> miss, mux picks data_in_2.
      run(0, 16, K_MISS, 1'b0, W1);
      // Second frame: full window captured at 14,15,0,1 -> inserted word.
      run(0, 15, K_INS, 1'b1, W1);
      // Stall at slot 15: slot holds, valid drops, data held.
      repeat (3) cyc(0, 1'b0, 1'b0, 1'b1, 136'h0DEAD, 136'h0BEEF, 136'h00777, K_NONE, W1);
      run(0, 16, K_INS, 1'b1, W1);
      // Sync at slot 15 before lane 1 is taken: lane 2 captured at slot 0, then miss.
      cyc(0, 1'b1, 1'b1, 1'b1, 136'h0E000, 136'h0E001, 136'h00100, K_NONE, W1);
      run(0, 2, K_MISS, 1'b1, W1);
      run(0, 16, K_INS, 1'b1, W1);
      // Async reset mid-frame at slot 9.
      run(0, 6, K_NONE, 1'b1, W1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      z.dut = 0; compare(z);
      exp_slot[0] = 0;
      exp_dout[0] = '0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      run(0, 16, K_MISS, 1'b0, W1);
      run(0, 3, K_INS, 1'b1, W1);
      cyc(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, K_NONE, W1);

      // Wide parameter set: lanes from slots 20..27 injected after slot 30.
      run(1, 33, K_INS, 1'b1, W2);
      cyc(1, 1'b0, 1'b0, 1'b0, '0, '0, '0, K_NONE, W2);

      repeat (2) @(negedge clk);
      #1;
      check("sb_drained", 136'(sb.size()), 136'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
